saturn_bus_prog_scheduler: RTL

SATURN_BUS_PROG_SCHEDULER -- requirements
Module: saturn_bus_prog_scheduler

---
 rtl/saturn_bus_prog_scheduler_pkg.sv | 41 ++++
 rtl/saturn_prog_fifo.sv | 69 ++++++
 rtl/saturn_bus_prog_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/saturn_bus_prog_scheduler_pkg.sv
// Shared bus-command definitions: BUSCMD codes, bus-program word fields,
// and the scheduler FSM state encodings.
// Imported by the scheduler top and the program FIFO.
package saturn_bus_prog_scheduler_pkg;

   // Bus-program word layout: the top bit marks a command word, the low
   // nibble carries either the command code or a data/address nibble.
   localparam int CMD_FLAG_BIT = 4;
   localparam int CODE_MSB     = 3;
   localparam int CODE_LSB     = 0;

   // Saturn bus command codes carried in the low nibble of a command word.
   typedef enum logic [3:0] {
      BUSCMD_PC_READ     = 4'h0,
      BUSCMD_DP_READ     = 4'h1,
      BUSCMD_PC_WRITE    = 4'h2,
      BUSCMD_DP_WRITE    = 4'h3,
      BUSCMD_LOAD_PC     = 4'h4,
      BUSCMD_LOAD_DP     = 4'h5,
      BUSCMD_CONFIGURE   = 4'h6,
      BUSCMD_UNCONFIGURE = 4'h7,
      BUSCMD_POLL        = 4'h8,
      BUSCMD_BUS_RESET   = 4'hB,
      BUSCMD_BUS_STANDBY = 4'hC,
      BUSCMD_ID          = 4'hD,
      BUSCMD_NOP         = 4'hF
   } buscmd_e;

   // Arbitration FSM: idle, or a requester owns the buffer until its
   // sequence ends with a last-flagged word.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } sched_state_e;

   // Requester identifiers used for the round-robin memory.
   localparam logic REQ_ID0 = 1'b0;
   localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/saturn_prog_fifo.sv
// Circular bus-program buffer: storage, read/write pointers, occupancy.
// Latency: a pushed word is visible at the read port one edge later (no bypass).
// Backpressure: pushes are dropped when full, pops when empty; o_full gates the requesters.
module saturn_prog_fifo
   import saturn_bus_prog_scheduler_pkg::*;
#(
   parameter int DEPTH_LOG2 = 5,
   parameter int WORD_W     = 5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_clk_en,
   input  logic                  i_push,
   input  logic [WORD_W-1:0]     i_push_word,
   input  logic                  i_pop,
   output logic [WORD_W-1:0]     o_word,
   output logic [DEPTH_LOG2:0]   o_level,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int                    DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

   logic [WORD_W-1:0]     r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign o_full    = (r_level == LEVEL_FULL);
   assign o_empty   = (r_level == '0);
   assign w_do_push = i_clk_en & i_push & ~o_full;
   assign w_do_pop  = i_clk_en & i_pop & ~o_empty;
   assign o_word    = r_mem[r_rptr];
   assign o_level   = r_level;

   // Storage write; contents are not reset, stale entries are simply unreachable.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_push_word;
      end
   end

   // Pointers wrap naturally at 2^DEPTH_LOG2; level tracks pushes minus pops.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LEVEL_ONE;
            2'b01:   r_level <= r_level - LEVEL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/saturn_bus_prog_scheduler.sv
// Arbitrates control-unit (req0) and debugger (req1) bus programs into one buffer.
// Latency: one-cycle grant from IDLE, then one word per cycle; buffer read is one edge after push.
// Backpressure: requester ready drops while the buffer is full; consumer pops on valid & ready.
// Optional feature macro: SATURN_BUS_SCHED_DBG_PORT_EN enables the debugger requester.
module saturn_bus_prog_scheduler
   import saturn_bus_prog_scheduler_pkg::*;
#(
   parameter int DEPTH_LOG2 = 5,
   parameter int WORD_W     = 5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_clk_en,
   input  logic                  i_req0_valid,
   input  logic [WORD_W-1:0]     i_req0_word,
   input  logic                  i_req0_last,
   output logic                  o_req0_ready,
   input  logic                  i_req1_valid,
   input  logic [WORD_W-1:0]     i_req1_word,
   input  logic                  i_req1_last,
   output logic                  o_req1_ready,
   output logic                  o_bus_valid,
   output logic [WORD_W-1:0]     o_bus_word,
   input  logic                  i_bus_ready,
   output logic [DEPTH_LOG2:0]   o_level,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_error
);

   sched_state_e      r_state;
   sched_state_e      w_next_state;
   logic              r_last_grant;   // requester that completed the most recent sequence
   logic              r_first_pend;   // next accepted word is the first of this grant
   logic              r_error;
   logic              w_ready0;
   logic              w_ready1;
   logic              w_accept;
   logic [WORD_W-1:0] w_push_word;
   logic              w_push_last;
   logic              w_full;
   logic              w_empty;

`ifndef SATURN_BUS_SCHED_DBG_PORT_EN
   // The debugger port is absent in this build; its inputs and the
   // round-robin memory have no effect.
   logic w_unused_req1;
   assign w_unused_req1 = ^{i_req1_valid, i_req1_word, i_req1_last, r_last_grant};
`endif

   // Next-state, requester ready and push selection for the arbitration FSM.
   always_comb begin
      w_next_state = r_state;
      w_ready0     = 1'b0;
      w_ready1     = 1'b0;
      w_accept     = 1'b0;
      w_push_word  = i_req0_word;
      w_push_last  = 1'b0;
      case (r_state)
         ST_IDLE: begin
`ifdef SATURN_BUS_SCHED_DBG_PORT_EN
            if (i_req0_valid && i_req1_valid) begin
               w_next_state = (r_last_grant == REQ_ID1) ? ST_GRANT0 : ST_GRANT1;
            end else if (i_req0_valid) begin
               w_next_state = ST_GRANT0;
            end else if (i_req1_valid) begin
               w_next_state = ST_GRANT1;
            end
`else
            if (i_req0_valid) begin
               w_next_state = ST_GRANT0;
            end
`endif
         end
         ST_GRANT0: begin
            w_ready0    = ~w_full;
            w_accept    = w_ready0 & i_req0_valid;
            w_push_word = i_req0_word;
            w_push_last = i_req0_last;
            if (w_accept && i_req0_last) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_GRANT1: begin
`ifdef SATURN_BUS_SCHED_DBG_PORT_EN
            w_ready1    = ~w_full;
            w_accept    = w_ready1 & i_req1_valid;
            w_push_word = i_req1_word;
            w_push_last = i_req1_last;
            if (w_accept && i_req1_last) begin
               w_next_state = ST_IDLE;
            end
`else
            w_next_state = ST_IDLE;
`endif
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // FSM state, round-robin memory, first-word tracking and sticky format error.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= REQ_ID1;
         r_first_pend <= 1'b0;
         r_error      <= 1'b0;
      end else if (i_clk_en) begin
         r_state <= w_next_state;
         if (r_state == ST_IDLE && w_next_state != ST_IDLE) begin
            r_first_pend <= 1'b1;
         end else if (w_accept) begin
            r_first_pend <= 1'b0;
         end
         if (w_accept && r_first_pend && !w_push_word[CMD_FLAG_BIT]) begin
            r_error <= 1'b1;
         end
         if (w_accept && w_push_last) begin
            r_last_grant <= (r_state == ST_GRANT1) ? REQ_ID1 : REQ_ID0;
         end
      end
   end

   saturn_prog_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WORD_W     (WORD_W)
   ) u_prog_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_clk_en    (i_clk_en),
      .i_push      (w_accept),
      .i_push_word (w_push_word),
      .i_pop       (i_bus_ready),
      .o_word      (o_bus_word),
      .o_level     (o_level),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   assign o_req0_ready = w_ready0;
   assign o_req1_ready = w_ready1;
   assign o_bus_valid  = ~w_empty;
   assign o_full       = w_full;
   assign o_empty      = w_empty;
   assign o_error      = r_error;

endmodule
